// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - multi-cycle data-memory responder for the MEM stage
// Holds the pipeline with stall for LATENCY busy cycles, then pulses rd_valid for one DONE cycle.
module dmem_responder #(
    parameter int LATENCY = 2,
    parameter int AW      = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        re,
    input  logic        we,
    input  logic [15:0] addr,
    input  logic [15:0] wrt_data,
    output logic [15:0] rd_data,
    output logic        rd_valid,
    output logic        stall,
    output logic        err
);

    localparam int DEPTH = 2 ** AW;
    localparam logic [3:0] CNT_LOAD = 4'(LATENCY - 1);

    if (LATENCY < 1 || LATENCY > 15) begin : g_bad_latency
        $error("dmem_responder: LATENCY must be in 1..15");
    end
    if (AW < 1 || AW > 16) begin : g_bad_aw
        $error("dmem_responder: AW must be in 1..16");
    end

    typedef enum logic [1:0] {
        S_IDLE,
        S_BUSY,
        S_DONE
    } state_e;

    state_e         state_q, state_d;
    logic [3:0]     cnt_q, cnt_d;
    logic           op_we_q, op_we_d;
    logic [AW-1:0]  addr_q, addr_d;
    logic [15:0]    data_q, data_d;
    logic [15:0]    rd_data_q, rd_data_d;
    logic           rd_valid_q, rd_valid_d;
    logic           err_q, err_d;
    logic           mem_we;
    logic           req_one;
    logic           req_both;

    logic [15:0]    mem_q [DEPTH];

    assign req_one  = re ^ we;
    assign req_both = re & we;

    // Upper address bits alias onto the low AW bits.
    if (AW < 16) begin : g_unused_addr
        logic unused_addr_hi;
        assign unused_addr_hi = ^addr[15:AW];
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        op_we_d    = op_we_q;
        addr_d     = addr_q;
        data_d     = data_q;
        rd_data_d  = rd_data_q;
        rd_valid_d = 1'b0;
        err_d      = 1'b0;
        mem_we     = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (req_one) begin
                    op_we_d = we;
                    addr_d  = addr[AW-1:0];
                    data_d  = wrt_data;
                    cnt_d   = CNT_LOAD;
                    state_d = S_BUSY;
                end else if (req_both) begin
                    err_d = 1'b1;
                end
            end
            S_BUSY: begin
                if (cnt_q == 4'd0) begin
                    mem_we     = op_we_q;
                    if (!op_we_q) begin
                        rd_data_d = mem_q[addr_q];
                    end
                    rd_valid_d = 1'b1;
                    state_d    = S_DONE;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            cnt_q      <= 4'd0;
            op_we_q    <= 1'b0;
            addr_q     <= '0;
            data_q     <= 16'd0;
            rd_data_q  <= 16'd0;
            rd_valid_q <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            op_we_q    <= op_we_d;
            addr_q     <= addr_d;
            data_q     <= data_d;
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
            err_q      <= err_d;
        end
    end

    // Array is not reset; a reset mid-access leaves state_q in IDLE so no write lands.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem_q[addr_q] <= data_q;
        end
    end

    assign stall    = ((state_q == S_IDLE) && req_one) || (state_q == S_BUSY);
    assign rd_data  = rd_data_q;
    assign rd_valid = rd_valid_q;
    assign err      = err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// tb/tb_dmem_responder.sv - directed and randomized bench for dmem_responder
module tb_dmem_responder;

    localparam int L  = 2;
    localparam int AW = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic        re;
    logic        we;
    logic [15:0] addr;
    logic [15:0] wrt_data;
    logic [15:0] rd_data;
    logic        rd_valid;
    logic        stall;
    logic        err;

    always #5 clk = ~clk;

    dmem_responder #(.LATENCY(L), .AW(AW)) dut (
        .clk      (clk),
        .rst      (rst),
        .re       (re),
        .we       (we),
        .addr     (addr),
        .wrt_data (wrt_data),
        .rd_data  (rd_data),
        .rd_valid (rd_valid),
        .stall    (stall),
        .err      (err)
    );

    int total = 0;
    int bad   = 0;

    // Transaction-level reference: an access accepted at cycle acc stalls
    // cycles acc..acc+L and completes (commit + rd_valid) in cycle acc+L+1.
    logic [15:0] mem_m [256];
    bit          known_m [256];
    logic [15:0] rd_m;
    bit          rd_known;
    bit          pend;
    int          acc;
    int          t;
    bit          op_w;
    logic [7:0]  op_a;
    logic [15:0] op_d;
    bit          err_pend;
    int          valid_seen;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp_v);
        total++;
        assert (obs === exp_v) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
        end
    endtask

    task automatic tick();
        logic exp_stall;
        logic exp_valid;
        logic exp_err;
        @(negedge clk);
        exp_err   = err_pend;
        err_pend  = 1'b0;
        exp_stall = 1'b0;
        exp_valid = 1'b0;
        if (pend) begin
            if (t <= acc + L) begin
                exp_stall = 1'b1;
            end else begin
                if (op_w) begin
                    mem_m[op_a]   = op_d;
                    known_m[op_a] = 1'b1;
                end else begin
                    rd_m     = mem_m[op_a];
                    rd_known = known_m[op_a];
                end
                exp_valid = 1'b1;
                pend      = 1'b0;
            end
        end else if (re ^ we) begin
            pend      = 1'b1;
            acc       = t;
            op_w      = we;
            op_a      = addr[7:0];
            op_d      = wrt_data;
            exp_stall = 1'b1;
        end else if (re && we) begin
            err_pend = 1'b1;
        end
        chk("stall", {15'd0, stall}, {15'd0, exp_stall});
        chk("rd_valid", {15'd0, rd_valid}, {15'd0, exp_valid});
        chk("err", {15'd0, err}, {15'd0, exp_err});
        if (rd_known) chk("rd_data", rd_data, rd_m);
        if (rd_valid === 1'b1) valid_seen++;
        t++;
        @(posedge clk);
        #1;
    endtask

    task automatic access(input bit r, input bit w, input logic [15:0] a, input logic [15:0] d);
        re = r; we = w; addr = a; wrt_data = d;
        tick();
        re = 1'b0; we = 1'b0;
        for (int i = 0; i < 20 && pend; i++) tick();
        chk("access_drained", {15'd0, pend}, 16'd0);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_rd_data"}, rd_data, 16'd0);
        chk({tag, "_rd_valid"}, {15'd0, rd_valid}, 16'd0);
        chk({tag, "_stall"}, {15'd0, stall}, 16'd0);
        chk({tag, "_err"}, {15'd0, err}, 16'd0);
    endtask

    initial begin
        rst = 1'b1; re = 1'b0; we = 1'b0; addr = 16'd0; wrt_data = 16'd0;
        pend = 1'b0; t = 0; rd_m = 16'd0; rd_known = 1'b1; err_pend = 1'b0;
        acc = 0; op_w = 1'b0; op_a = 8'd0; op_d = 16'd0; valid_seen = 0;
        #12;
        check_reset_outputs("reset");
        @(posedge clk); #1;
        rst = 1'b0;

        // Reset aborts an in-flight write.
        access(1'b0, 1'b1, 16'h0010, 16'h1234);
        re = 1'b0; we = 1'b1; addr = 16'h0010; wrt_data = 16'hBEEF;
        tick();
        re = 1'b0; we = 1'b0;
        tick();
        #2;
        rst = 1'b1;
        #1;
        check_reset_outputs("async_reset");
        pend = 1'b0; rd_m = 16'd0; rd_known = 1'b1; err_pend = 1'b0;
        @(posedge clk); #3;
        rst = 1'b0;
        access(1'b1, 1'b0, 16'h0010, 16'h0000);
        chk("abort_keeps_old", rd_data, 16'h1234);

        // Write then read back, and the aliased address.
        access(1'b0, 1'b1, 16'h0010, 16'hBEEF);
        chk("write_keeps_rd_data", rd_data, 16'h1234);
        access(1'b1, 1'b0, 16'h0010, 16'h0000);
        chk("raw_readback", rd_data, 16'hBEEF);
        valid_seen = 0;
        access(1'b1, 1'b0, 16'h0110, 16'h0000);
        chk("alias_read", rd_data, 16'hBEEF);
        chk("alias_one_pulse", 16'(valid_seen), 16'd1);

        // re and we together in IDLE.
        valid_seen = 0;
        re = 1'b1; we = 1'b1; addr = 16'h0010; wrt_data = 16'h0BAD;
        tick();
        re = 1'b0; we = 1'b0;
        tick();
        tick();
        chk("both_no_valid", 16'(valid_seen), 16'd0);
        access(1'b1, 1'b0, 16'h0010, 16'h0000);
        chk("both_mem_unchanged", rd_data, 16'hBEEF);

        // Continuous re with changing addr: one access per L+2 cycles.
        valid_seen = 0;
        re = 1'b1; we = 1'b0;
        for (int i = 0; i < 12; i++) begin
            addr = 16'(i * 37);
            tick();
        end
        re = 1'b0;
        chk("held_re_pulses", 16'(valid_seen), 16'd3);
        for (int i = 0; i < 20 && pend; i++) tick();

        // Inputs toggled during BUSY are ignored.
        re = 1'b0; we = 1'b1; addr = 16'h0020; wrt_data = 16'hA5A5;
        tick();
        for (int i = 0; i < L + 1; i++) begin
            re = 1'($urandom); we = 1'($urandom);
            addr = 16'($urandom); wrt_data = 16'($urandom);
            tick();
        end
        re = 1'b0; we = 1'b0;
        for (int i = 0; i < 20 && pend; i++) tick();
        access(1'b1, 1'b0, 16'h0020, 16'h0000);
        chk("busy_inputs_ignored", rd_data, 16'hA5A5);

        // Randomized traffic over a small aliased address window.
        for (int i = 0; i < 16; i++) access(1'b0, 1'b1, 16'(i), 16'($urandom));
        for (int i = 0; i < 400; i++) begin
            re = ($urandom_range(0, 3) != 0);
            we = ($urandom_range(0, 2) == 0);
            addr = {8'($urandom), 4'h0, 4'($urandom)};
            wrt_data = 16'($urandom);
            tick();
        end
        re = 1'b0; we = 1'b0;
        for (int i = 0; i < 20 && (pend || err_pend); i++) tick();
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
